// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: decode control, redirect, instruction memory port and IF/ID register.
// master = fetch unit, slave = surrounding pipeline and memory.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 37
);
  logic                   stall;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_target;
  logic                   imem_rd_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   if_id_valid;
  logic [INSTR_WIDTH-1:0] if_id_instruction;
  logic [PC_WIDTH-1:0]    if_id_pc;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_rd_en, imem_addr, if_id_valid, if_id_instruction, if_id_pc
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_rd_en, imem_addr, if_id_valid, if_id_instruction, if_id_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC + 1-cycle imem fetch into IF/ID; fetch-to-IF/ID latency 2 cycles, redirect-to-valid 3.
// Decode stall holds IF/ID and parks the in-flight response in a one-entry skid buffer.
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 37,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                     clk,
  input logic                     reset,
  instruction_fetch_unit_if.master bus
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                resp_pending_q, resp_pending_d;
  logic                if_id_valid_q, if_id_valid_d;
  logic                skid_valid_q, skid_valid_d;
  entry_t              if_id_q, if_id_d;
  entry_t              skid_q, skid_d;
  entry_t              resp_entry;
  logic                rd_en;

  assign rd_en      = !reset && !bus.stall && !bus.redirect_valid;
  assign resp_entry = '{instr: bus.imem_rdata, pc: req_pc_q};

  always_comb begin
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    resp_pending_d = rd_en;
    if_id_valid_d  = if_id_valid_q;
    if_id_d        = if_id_q;
    skid_valid_d   = skid_valid_q;
    skid_d         = skid_q;

    if (rd_en) begin
      pc_d     = pc_q + PC_ONE;
      req_pc_d = pc_q;
    end

    if (bus.redirect_valid) begin
      // In-flight response is dropped; IF/ID payload may stay stale.
      pc_d           = bus.redirect_target;
      resp_pending_d = 1'b0;
      if_id_valid_d  = 1'b0;
      skid_valid_d   = 1'b0;
    end else if (resp_pending_q) begin
      if (!if_id_valid_q || !bus.stall) begin
        if_id_d       = resp_entry;
        if_id_valid_d = 1'b1;
      end else begin
        skid_d       = resp_entry;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q && !bus.stall) begin
      if_id_d       = skid_q;
      if_id_valid_d = 1'b1;
      skid_valid_d  = 1'b0;
    end else if (!bus.stall) begin
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      req_pc_q       <= '0;
      resp_pending_q <= 1'b0;
      if_id_valid_q  <= 1'b0;
      if_id_q        <= '0;
      skid_valid_q   <= 1'b0;
      skid_q         <= '0;
    end else begin
      pc_q           <= pc_d;
      req_pc_q       <= req_pc_d;
      resp_pending_q <= resp_pending_d;
      if_id_valid_q  <= if_id_valid_d;
      if_id_q        <= if_id_d;
      skid_valid_q   <= skid_valid_d;
      skid_q         <= skid_d;
    end
  end

  assign bus.imem_rd_en        = rd_en;
  assign bus.imem_addr         = pc_q;
  assign bus.if_id_valid       = if_id_valid_q;
  assign bus.if_id_instruction = if_id_q.instr;
  assign bus.if_id_pc          = if_id_q.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns addr + 0x100 one cycle after a read.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  instruction_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(37)) bus ();

  instruction_fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(37), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] instr_of(input logic [31:0] a);
    return {5'b0, a} + 37'h100;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= instr_of(bus.imem_addr);
  end

  // A response must never land while the skid buffer is occupied.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (dut.resp_pending_q && dut.skid_valid_q) begin
        failures++;
        $display("FAIL skid_resp_overlap: resp_pending=1 skid_valid=1 required not both");
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if_id(input string name, input logic exp_vld, input logic [31:0] exp_pc);
    @(negedge clk);
    checks++;
    if (bus.if_id_valid !== exp_vld) begin
      failures++;
      $display("FAIL %s valid: got %b expected %b", name, bus.if_id_valid, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (bus.if_id_pc !== exp_pc || bus.if_id_instruction !== instr_of(exp_pc)) begin
        failures++;
        $display("FAIL %s pc/instr: got %h/%h expected %h/%h", name,
                 bus.if_id_pc, bus.if_id_instruction, exp_pc, instr_of(exp_pc));
      end
    end
  endtask

  task automatic chk_fetch(input string name, input logic exp_en, input logic [31:0] exp_addr);
    checks++;
    if (bus.imem_rd_en !== exp_en || bus.imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s fetch: got en=%b addr=%h expected en=%b addr=%h", name,
               bus.imem_rd_en, bus.imem_addr, exp_en, exp_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.imem_rdata = '0;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 32'h0 || bus.if_id_instruction !== 37'h0) begin
      failures++;
      $display("FAIL reset_if_id: got v=%b pc=%h ins=%h expected 0/0/0",
               bus.if_id_valid, bus.if_id_pc, bus.if_id_instruction);
    end
    chk_fetch("reset", 1'b0, 32'h0);
  endtask

  // Leaves the bench in cycle 7: IF/ID=pc5, pc6 in flight, pc_q=7.
  task automatic test_free_run();
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk_if_id($sformatf("free_run_c%0d", k), k >= 2, 32'(k - 2));
      chk_fetch($sformatf("free_run_c%0d", k), 1'b1, 32'(k));
      cyc();
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk_if_id($sformatf("stall_hold%0d", s), 1'b1, 32'd5);
      chk_fetch($sformatf("stall_hold%0d", s), 1'b0, 32'd7);
      if (s > 0) begin
        checks++;
        if (dut.skid_valid_q !== 1'b1 || dut.skid_q.pc !== 32'd6) begin
          failures++;
          $display("FAIL stall_skid%0d: got v=%b pc=%h expected 1/6", s,
                   dut.skid_valid_q, dut.skid_q.pc);
        end
      end
      cyc();
    end
    bus.stall = 1'b0;
    chk_if_id("stall_release", 1'b1, 32'd5);
    chk_fetch("stall_release", 1'b1, 32'd7);
    cyc();
    chk_if_id("stall_drain", 1'b1, 32'd6);
    cyc();
    chk_if_id("stall_after1", 1'b1, 32'd7);
    cyc();
  endtask

  // Entered with IF/ID=pc8 and pc9 in flight.
  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h40;
    chk_if_id("redir_t0", 1'b1, 32'd8);
    chk_fetch("redir_t0", 1'b0, 32'd10);
    cyc();
    bus.redirect_valid = 1'b0;
    chk_if_id("redir_t1", 1'b0, 32'h0);
    chk_fetch("redir_t1", 1'b1, 32'h40);
    cyc();
    chk_if_id("redir_t2", 1'b0, 32'h0);
    cyc();
    chk_if_id("redir_t3", 1'b1, 32'h40);
    cyc();
    chk_if_id("redir_t4", 1'b1, 32'h41);
    cyc();
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1'b1;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h80;
    @(negedge clk);
    checks++;
    if (dut.skid_valid_q !== 1'b1) begin
      failures++;
      $display("FAIL rs_skid_full: got %b expected 1", dut.skid_valid_q);
    end
    cyc();
    bus.redirect_valid = 1'b0;
    chk_if_id("rs_after", 1'b0, 32'h0);
    chk_fetch("rs_after", 1'b0, 32'h80);
    checks++;
    if (dut.skid_valid_q !== 1'b0) begin
      failures++;
      $display("FAIL rs_skid_clear: got %b expected 0", dut.skid_valid_q);
    end
    cyc();
    bus.stall = 1'b0;
    chk_if_id("rs_release", 1'b0, 32'h0);
    chk_fetch("rs_release", 1'b1, 32'h80);
    cyc();
    chk_if_id("rs_bubble", 1'b0, 32'h0);
    cyc();
    chk_if_id("rs_target", 1'b1, 32'h80);
    cyc();
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFE;
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_fetch("wrap_t1", 1'b1, 32'hFFFF_FFFE);
    cyc();
    @(negedge clk);
    chk_fetch("wrap_t2", 1'b1, 32'hFFFF_FFFF);
    cyc();
    chk_if_id("wrap_t3", 1'b1, 32'hFFFF_FFFE);
    chk_fetch("wrap_t3", 1'b1, 32'h0);
    cyc();
    chk_if_id("wrap_t4", 1'b1, 32'hFFFF_FFFF);
    cyc();
    chk_if_id("wrap_t5", 1'b1, 32'h0);
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    bus.stall = 1'b1;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.skid_valid_q !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_skid_full: got %b expected 1", dut.skid_valid_q);
    end
    chk_fetch("rst_mid_in_reset", 1'b0, 32'h0 + bus.imem_addr);
    cyc();
    reset = 1'b0;
    bus.stall = 1'b0;
    chk_if_id("rst_mid_c0", 1'b0, 32'h0);
    chk_fetch("rst_mid_c0", 1'b1, 32'h0);
    cyc();
    chk_if_id("rst_mid_c1", 1'b0, 32'h0);
    chk_fetch("rst_mid_c1", 1'b1, 32'h1);
    cyc();
    chk_if_id("rst_mid_c2", 1'b1, 32'h0);
    cyc();
    chk_if_id("rst_mid_c3", 1'b1, 32'h1);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
